// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master. CPOL/CPHA are selected per transfer, and the SCLK half-period
// is CLK_DIV clk cycles. Every output is registered.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic       start,
    input  logic [7:0] datai,
    output logic [7:0] datao,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       csb,
    output logic       dout,
    input  logic       din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] RELOAD    = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_EDGE = 5'd16;

    state_t     state_r;
    logic [7:0] cnt_r;
    logic [4:0] edge_r;
    logic [7:0] tx_r;
    logic [7:0] rx_r;
    logic       cpol_r;
    logic       cpha_r;
    logic       leading_s;
    logic       sample_s;

    // Classify the upcoming toggle: odd edges lead, and CPHA picks which edge kind samples din.
    always_comb begin
        leading_s = ~edge_r[0];
        sample_s  = leading_s ^ cpha_r;
    end

    // Transfer sequencer: state, half-period and edge counters, shift registers, and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            edge_r  <= 5'd0;
            tx_r    <= 8'd0;
            rx_r    <= 8'd0;
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            datao   <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            csb     <= 1'b1;
            dout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sclk <= CPOL;
                    done <= 1'b0;
                    if (start) begin
                        state_r <= SETUP;
                        busy    <= 1'b1;
                        csb     <= 1'b0;
                        cnt_r   <= RELOAD;
                        edge_r  <= 5'd0;
                        tx_r    <= datai;
                        rx_r    <= 8'd0;
                        cpol_r  <= CPOL;
                        cpha_r  <= CPHA;
                        // In mode CPHA=0 the first bit must already be on the line at the first leading edge.
                        dout    <= CPHA ? 1'b0 : datai[7];
                    end else begin
                        busy <= 1'b0;
                        csb  <= 1'b1;
                        dout <= 1'b0;
                    end
                end
                SETUP, XFER: begin
                    if (cnt_r == 8'd0) begin
                        sclk    <= ~sclk;
                        cnt_r   <= RELOAD;
                        state_r <= (edge_r == (LAST_EDGE - 5'd1)) ? HOLD : XFER;
                        if (edge_r != LAST_EDGE) begin
                            edge_r <= edge_r + 5'd1;
                        end
                        if (sample_s) begin
                            rx_r <= {rx_r[6:0], din};
                        end else if (cpha_r) begin
                            dout <= tx_r[7];
                            tx_r <= {tx_r[6:0], 1'b0};
                        end else begin
                            dout <= tx_r[6];
                            tx_r <= {tx_r[6:0], 1'b0};
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                HOLD: begin
                    sclk <= cpol_r;
                    if (done) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        sclk    <= CPOL;
                    end else if (cnt_r == 8'd0) begin
                        csb   <= 1'b1;
                        dout  <= 1'b0;
                        done  <= 1'b1;
                        datao <= rx_r;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    csb     <= 1'b1;
                    dout    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master. It drives random modes and data against a behavioural SPI slave or a
// loopback, and it also runs a CLK_DIV=1 instance with back-to-back starts.
module tb_spi_master;

    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       rst, cpol, cpha, start, din;
    logic [7:0] datai, datao;
    logic       busy, done, sclk, csb, dout;
    logic       start1;
    logic [7:0] datai1, datao1;
    logic       busy1, done1, sclk1, csb1, dout1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = -1000;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] slv;
        bit         chk_slv;
        int         cyc;
        logic       cpol;
    } exp_t;
    exp_t sb[$];

    // behavioural slave state
    bit         loop_en = 1'b1;
    logic [7:0] s_tx = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
    logic       s_bit = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
    logic       sclk_prev = 1'b0, csb_prev = 1'b1, lead;
    int         s_edges = 0;

    assign din = loop_en ? dout : s_bit;

    spi_master #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .CPOL(cpol), .CPHA(cpha), .start(start), .datai(datai),
        .datao(datao), .busy(busy), .done(done), .sclk(sclk), .csb(csb), .dout(dout), .din(din)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .CPOL(1'b0), .CPHA(1'b0), .start(start1), .datai(datai1),
        .datao(datao1), .busy(busy1), .done(done1), .sclk(sclk1), .csb(csb1), .dout(dout1), .din(dout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Behavioural SPI slave: it reacts to the SCLK edges it observes while csb is low.
    always @(negedge clk) begin
        if (csb_prev && !csb) begin
            s_edges = 0;
            s_sh    = s_tx;
            s_rx    = 8'h00;
            s_bit   = s_cpha ? 1'b0 : s_sh[7];
        end else if (!csb && (sclk !== sclk_prev)) begin
            s_edges++;
            lead = (sclk != s_cpol);
            if (lead == !s_cpha) begin
                s_rx = {s_rx[6:0], dout};
            end else if (s_cpha) begin
                s_bit = s_sh[7];
                s_sh  = {s_sh[6:0], 1'b0};
            end else begin
                s_sh  = {s_sh[6:0], 1'b0};
                s_bit = s_sh[7];
            end
        end
        sclk_prev = sclk;
        csb_prev  = csb;
    end

    // Monitor: checks select timing and dout gating, and pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (csb) chk("dout_zero_when_deselected", dout, 1'b0);
            if (cyc == acc_cyc + 1) begin
                chk("csb_low_cycle1", csb, 1'b0);
                chk("busy_high_cycle1", busy, 1'b1);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 want no done (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("datao", datao, e.rx);
                    chk("sclk_edges", s_edges, 16);
                    chk("sclk_at_cpol_on_done", sclk, e.cpol);
                    chk("csb_high_on_done", csb, 1'b1);
                    if (e.chk_slv) chk("slave_rx", s_rx, e.slv);
                end
            end
        end
    end

    task automatic launch(input logic pol, input logic pha, input logic [7:0] data,
                          input bit loop, input logic [7:0] sbyte);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) note_fail("launch_wait_idle");
        cpol = pol; cpha = pha; s_cpol = pol; s_cpha = pha; loop_en = loop; s_tx = sbyte;
        @(negedge clk);
        chk("sclk_idle_level", sclk, pol);
        datai = data;
        start = 1'b1;
        acc_cyc = cyc;
        e.rx = loop ? data : sbyte;
        e.slv = data;
        e.chk_slv = !loop;
        e.cyc = cyc + 1 + 17 * DIV;
        e.cpol = pol;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        datai = 8'($urandom);
        cpha  = 1'($urandom);
        cpol  = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            note_fail(name);
            sb.delete();
        end
    endtask

    initial begin
        int n, a0, ndone;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; cpol = 1'b0; cpha = 1'b0;
        datai = 8'h00; datai1 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_csb", csb, 1'b1);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_datao", datao, 8'h00);
        chk("rst_dout", dout, 1'b0);
        chk("rst_csb1", csb1, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // mode 0 loopback, mode 3 with a real slave, then modes 1 and 2 in loopback
        launch(1'b0, 1'b0, 8'hA5, 1'b1, 8'h00); wait_done("mode0_loop");
        launch(1'b1, 1'b1, 8'hC3, 1'b0, 8'h3C); wait_done("mode3_slave");
        @(negedge clk); chk("mode3_sclk_idle_after", sclk, cpol);
        launch(1'b0, 1'b1, 8'h81, 1'b1, 8'h00); wait_done("mode1_loop");
        launch(1'b1, 1'b0, 8'h81, 1'b1, 8'h00); wait_done("mode2_loop");

        // start during an active transfer must be ignored
        launch(1'b0, 1'b0, 8'h3C, 1'b0, 8'h66);
        while (cyc < acc_cyc + 10) @(negedge clk);
        datai = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start");
        repeat (50) @(negedge clk);
        chk("ignored_start_idle", busy, 1'b0);

        // reset in the middle of a transfer
        launch(1'b0, 1'b0, 8'hE7, 1'b1, 8'h00);
        n = 0;
        while (s_edges < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (s_edges < 7) note_fail("wait_7_edges");
        rst = 1'b1;
        cpol = 1'b1;
        @(posedge clk); #1;
        chk("midrst_csb", csb, 1'b1);
        chk("midrst_sclk", sclk, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_datao", datao, 8'h00);
        chk("midrst_done", done, 1'b0);
        sb.delete();
        acc_cyc = -1000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_sclk_follows_cpol", sclk, 1'b1);
        repeat (60) @(negedge clk);
        chk("post_rst_no_busy", busy, 1'b0);
        launch(1'b0, 1'b0, 8'h5A, 1'b1, 8'h00); wait_done("after_reset_xfer");

        // randomized transfers
        for (int i = 0; i < 12; i++) begin
            launch(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
            wait_done("random_xfer");
        end

        // CLK_DIV=1 with start held high
        @(negedge clk);
        datai1 = 8'h96; start1 = 1'b1; a0 = cyc; ndone = 0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (cyc == a0 + 1) begin
                datai1 = 8'h3B;
                chk("b2b_csb_cycle1", csb1, 1'b0);
            end
            if (done1) begin
                ndone++;
                if (ndone == 1) begin
                    chk("b2b_done1_cycle", cyc - a0, 18);
                    chk("b2b_datao1", datao1, 8'h96);
                end else begin
                    chk("b2b_done2_cycle", cyc - a0, 37);
                    chk("b2b_datao2", datao1, 8'h3B);
                end
            end
            if (cyc == a0 + 19) begin
                chk("b2b_csb_gap", csb1, 1'b1);
                chk("b2b_busy_gap", busy1, 1'b0);
            end
            if (cyc == a0 + 20) chk("b2b_csb_fall2", csb1, 1'b0);
        end
        start1 = 1'b0;
        chk("b2b_done_count", ndone, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port CPOL  input  1  SCLK idle level; sampled when start is accepted.
REQ-005 SHALL have port CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled when start is accepted.
REQ-006 SHALL have port start  input  1  transfer request; single-cycle pulse or level.
REQ-007 SHALL have port datai  input  8  byte to transmit; captured when start is accepted.
REQ-008 SHALL have port datao  output  8  byte received; valid from the done cycle until the next accepted start.
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-011 SHALL have port sclk  output  1  SPI clock to the slave.
REQ-012 SHALL have port csb  output  1  active-low chip select to the slave.
REQ-013 SHALL have port dout  output  1  MOSI; drives the slave's din.
REQ-014 SHALL have port din  input  1  MISO; driven by the slave's dout; treated as synchronous to clk.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, XFER and HOLD; busy SHALL be high whenever the state is not IDLE.
REQ-016 SHALL accept start only in IDLE with busy low; start in any other state SHALL be ignored, with no queuing.
REQ-017 SHALL define acceptance cycle as cycle 0 and then latch datai into the shift register, and latch CPOL and CPHA.
REQ-018 SHALL, at cycle 1, drive csb to 0, drive busy to 1 and enter SETUP.
REQ-019 SHALL, while in IDLE, drive sclk to the live CPOL input each cycle.
REQ-020 SHALL, from cycle 1 through the end of the transfer, hold sclk at the latched CPOL except at toggles.
REQ-021 SHALL, in SETUP, hold for CLK_DIV cycles and then enter XFER.
REQ-022 SHALL, in XFER, toggle sclk exactly 16 times, at cycles 1+k*CLK_DIV for k = 1..16; odd k is a leading edge, even k a trailing edge.
REQ-023 SHALL transmit MSB first and receive MSB first.
REQ-024 SHALL, when CPHA=0, present bit 7 on dout at cycle 1, sample din at each leading edge, and shift the next dout bit at each trailing edge.
REQ-025 SHALL, when CPHA=1, shift dout at each leading edge, with bit 7 at the first leading edge, and sample din at each trailing edge.
REQ-026 SHALL sample din in the same clk cycle that sclk toggles.
REQ-027 SHALL drive dout to 0 whenever csb is 1.
REQ-028 SHALL, after the 16th edge, enter HOLD for CLK_DIV cycles, keeping csb at 0 and sclk at the latched CPOL.
REQ-029 SHALL, at cycle 1+17*CLK_DIV, drive csb to 1, pulse done for one cycle and update datao with the full received byte.
REQ-030 SHALL return to IDLE with busy low at cycle 2+17*CLK_DIV; the earliest next acceptance is that cycle.
REQ-031 SHALL use an 8-bit half-period counter that reloads to CLK_DIV-1 at each phase boundary, and a 5-bit edge counter that saturates at 16.
REQ-032 SHALL NOT let changes on datai, CPOL or CPHA during busy affect the transfer in progress.

Reset
REQ-033 SHALL, while rst is high (at any time, including mid-transfer), force state to IDLE, csb=1, sclk=0, dout=0, busy=0, done=0, datao=8'h00, and clear all counters and the shift register.
REQ-034 SHALL, after rst is released, make sclk follow CPOL from the first clk edge and generate no done pulse for an aborted transfer.

Verification
REQ-035 SHALL cover: CLK_DIV=2, CPOL=0, CPHA=0, dout looped back to din, datai=8'hA5 -> csb low at cycle 1, 16 sclk edges, done at cycle 35, datao=8'hA5.
REQ-036 SHALL cover: CPOL=1, CPHA=1, behavioural SPI slave in mode 3 returning 8'h3C, master datai=8'hC3 -> slave receives 8'hC3, datao=8'h3C, sclk idles at 1 before and after.
REQ-037 SHALL cover: modes 1 and 2 with datai=8'h81 under loopback -> datao=8'h81, and sclk idle level equal to CPOL in each mode.
REQ-038 SHALL cover: start pulsed at cycle 10 of an active transfer with datai=8'hFF -> ignored, current byte unchanged, exactly one done pulse.
REQ-039 SHALL cover: rst asserted after the 7th sclk edge -> next clk edge shows csb=1, sclk=0, busy=0, datao=8'h00, and a subsequent transfer of 8'h5A completes correctly.
REQ-040 SHALL cover: CLK_DIV=1 and back-to-back starts held high -> done at cycle 18, next csb fall at cycle 20, and csb high for at least one cycle between transfers.
